// File: rtl/alu_ctrl_pkg.sv
// Shared types, opcode constants, instruction field positions and flag masks
// for the alu_ctrl instruction sequencer.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB} state_e;
  typedef enum logic [1:0] {FMT_BYTE = 2'b00, FMT_BIT = 2'b01, FMT_LIT = 2'b10, FMT_CTRL = 2'b11} fmt_e;
  typedef enum logic [1:0] {DEST_NONE, DEST_W, DEST_F} dest_e;
  typedef enum logic [1:0] {BSEL_ZERO, BSEL_FILE, BSEL_LIT} bsel_e;

  localparam logic [3:0] ALU_PASSB = 4'd0;
  localparam logic [3:0] ALU_PASSA = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_INC   = 4'd6;
  localparam logic [3:0] ALU_DEC   = 4'd7;
  localparam logic [3:0] ALU_RLF   = 4'd8;
  localparam logic [3:0] ALU_COM   = 4'd9;
  localparam logic [3:0] ALU_IOR   = 4'd10;
  localparam logic [3:0] ALU_SWAP  = 4'd11;
  localparam logic [3:0] ALU_CLR   = 4'd12;
  localparam logic [3:0] ALU_BSF   = 4'd13;
  localparam logic [3:0] ALU_BCF   = 4'd14;
  localparam logic [3:0] ALU_RRF   = 4'd15;

  localparam logic [11:0] IR_NOP = 12'hF00;

  localparam int FMT_LSB = 10;
  localparam int OP_LSB  = 6;
  localparam int D_BIT   = 5;
  localparam int BIT_LSB = 6;
  localparam int CLR_BIT = 9;
  localparam int SEL_LSB = 8;

  // One bit per ALU opcode: set where that opcode updates the flag.
  localparam logic [15:0] C_UPD_MASK = 16'h810C;
  localparam logic [15:0] Z_UPD_MASK = 16'h16FF;

  function automatic logic [3:0] lit_opcode(input logic [1:0] sel);
    case (sel)
      2'b00:   return ALU_PASSB;
      2'b01:   return ALU_ADD;
      2'b10:   return ALU_AND;
      default: return ALU_IOR;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: upper instruction bits to ALU controls,
// operand-b source, destination and flag/branch qualifiers.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [11:5] ir_hi_i,
  output logic [3:0]  alu_inst_o,
  output logic [2:0]  alu_bit_o,
  output bsel_e       b_sel_o,
  output dest_e       dest_o,
  output logic        upd_c_o,
  output logic        upd_z_o,
  output logic        is_goto_o,
  output logic        is_skipz_o
);

  fmt_e       fmt;
  logic [3:0] op;

  assign fmt = fmt_e'(ir_hi_i[FMT_LSB +: 2]);

  always_comb begin
    alu_inst_o = '0;
    alu_bit_o  = '0;
    b_sel_o    = BSEL_ZERO;
    dest_o     = DEST_NONE;
    upd_c_o    = 1'b0;
    upd_z_o    = 1'b0;
    is_goto_o  = 1'b0;
    is_skipz_o = 1'b0;
    op         = '0;
    case (fmt)
      FMT_BYTE: begin
        op         = ir_hi_i[OP_LSB +: 4];
        alu_inst_o = op;
        b_sel_o    = BSEL_FILE;
        dest_o     = ir_hi_i[D_BIT] ? DEST_F : DEST_W;
        upd_c_o    = C_UPD_MASK[op];
        upd_z_o    = Z_UPD_MASK[op];
      end
      FMT_BIT: begin
        alu_inst_o = ir_hi_i[CLR_BIT] ? ALU_BCF : ALU_BSF;
        alu_bit_o  = ir_hi_i[BIT_LSB +: 3];
        b_sel_o    = BSEL_FILE;
        dest_o     = DEST_F;
      end
      FMT_LIT: begin
        op         = lit_opcode(ir_hi_i[SEL_LSB +: 2]);
        alu_inst_o = op;
        b_sel_o    = BSEL_LIT;
        dest_o     = DEST_W;
        upd_c_o    = C_UPD_MASK[op];
        upd_z_o    = 1'b1;
      end
      FMT_CTRL: begin
        is_goto_o  = ~ir_hi_i[CLR_BIT];
        is_skipz_o = (ir_hi_i[SEL_LSB +: 2] == 2'b10);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Four-phase instruction sequencer (fetch/decode/exec/writeback) owning PC,
// W and the C/Z flags, driving the external 8-bit ALU and register file.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int RF_AW = 5
) (
  input  logic             clk2,
  input  logic             reset,
  output logic [PC_W-1:0]  pm_addr,
  output logic             pm_req,
  input  logic             pm_valid,
  input  logic [11:0]      pm_data,
  output logic [RF_AW-1:0] rf_addr,
  input  logic [7:0]       rf_rdata,
  output logic [7:0]       rf_wdata,
  output logic             rf_we,
  output logic [3:0]       alu_inst,
  output logic [2:0]       alu_bit,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_ans,
  input  logic             alu_carry,
  input  logic             alu_z,
  output logic [7:0]       w_reg,
  output logic [1:0]       status
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [11:0]     ir_q, ir_d;
  logic [7:0]      w_q, w_d;
  logic [7:0]      result_q, result_d;
  logic            c_q, c_d, z_q, z_d;

  bsel_e b_sel;
  dest_e dest;
  logic  upd_c, upd_z, is_goto, is_skipz;

  alu_ctrl_decode u_decode (
    .ir_hi_i    (ir_q[11:5]),
    .alu_inst_o (alu_inst),
    .alu_bit_o  (alu_bit),
    .b_sel_o    (b_sel),
    .dest_o     (dest),
    .upd_c_o    (upd_c),
    .upd_z_o    (upd_z),
    .is_goto_o  (is_goto),
    .is_skipz_o (is_skipz)
  );

  always_comb begin
    case (b_sel)
      BSEL_FILE: alu_b = rf_rdata;
      BSEL_LIT:  alu_b = ir_q[7:0];
      default:   alu_b = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    w_d      = w_q;
    c_d      = c_q;
    z_d      = z_q;
    result_d = result_q;
    case (state_q)
      ST_FETCH: begin
        if (pm_valid) begin
          ir_d    = pm_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        result_d = alu_ans;
        if (upd_c) c_d = alu_carry;
        if (upd_z) z_d = alu_z;
        // PC already points past the SKIPZ, so one more increment skips.
        if (is_goto)                pc_d = PC_W'(ir_q[8:0]);
        else if (is_skipz && z_q)   pc_d = pc_q + PC_W'(1);
        state_d = ST_WB;
      end
      ST_WB: begin
        if (dest == DEST_W) w_d = result_q;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= IR_NOP;
      w_q      <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      w_q      <= w_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end

  // Gated by reset so a reset landing in WB drops the write that same cycle.
  assign pm_req   = reset && (state_q == ST_FETCH);
  assign rf_we    = reset && (state_q == ST_WB) && (dest == DEST_F);
  assign pm_addr  = pc_q;
  assign rf_addr  = ir_q[RF_AW-1:0];
  assign rf_wdata = result_q;
  assign alu_a    = w_q;
  assign w_reg    = w_q;
  assign status   = {c_q, z_q};

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: behavioural ALU and register file around
// the DUT, an architectural W/flag/PC model, and a queue of expected writes.
module tb_alu_ctrl;

  logic        clk2 = 1'b0;
  logic        reset;
  logic [8:0]  pm_addr;
  logic        pm_req;
  logic        pm_valid;
  logic [11:0] pm_data;
  logic [4:0]  rf_addr;
  logic [7:0]  rf_rdata;
  logic [7:0]  rf_wdata;
  logic        rf_we;
  logic [3:0]  alu_inst;
  logic [2:0]  alu_bit;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_ans;
  logic        alu_carry;
  logic        alu_z;
  logic [7:0]  w_reg;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rf_mem [32];
  logic [7:0]  m_rf   [32];
  logic [12:0] exp_wr_q [$];
  logic [12:0] mon_exp;
  logic [7:0]  m_w;
  logic        m_c, m_z;
  logic [8:0]  m_pc;
  logic [8:0]  alu_sum;

  alu_ctrl #(.PC_W(9), .RF_AW(5)) dut (
    .clk2(clk2), .reset(reset), .pm_addr(pm_addr), .pm_req(pm_req),
    .pm_valid(pm_valid), .pm_data(pm_data), .rf_addr(rf_addr),
    .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .alu_inst(alu_inst), .alu_bit(alu_bit), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ans(alu_ans), .alu_carry(alu_carry), .alu_z(alu_z),
    .w_reg(w_reg), .status(status)
  );

  always #5 clk2 = ~clk2;

  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign rf_rdata = rf_mem[rf_addr];

  always_comb begin
    alu_carry = 1'b0;
    case (alu_inst)
      4'd2:    begin alu_ans = alu_sum[7:0]; alu_carry = alu_sum[8]; end
      4'd4:    alu_ans = alu_a & alu_b;
      4'd10:   alu_ans = alu_a | alu_b;
      4'd13:   alu_ans = alu_b | (8'd1 << alu_bit);
      4'd14:   alu_ans = alu_b & ~(8'd1 << alu_bit);
      default: alu_ans = alu_b;
    endcase
    alu_z = (alu_ans == 8'h00);
  end

  always @(posedge clk2) if (rf_we === 1'b1) rf_mem[rf_addr] <= rf_wdata;

  always @(negedge clk2) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: addr=%0d data=%02h, required no write", rf_addr, rf_wdata);
      end else begin
        mon_exp = exp_wr_q.pop_front();
        if ({rf_addr, rf_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL rf_write: addr=%0d data=%02h, required addr=%0d data=%02h",
                   rf_addr, rf_wdata, mon_exp[12:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic model_reset();
    m_w = 8'h00; m_c = 1'b0; m_z = 1'b0; m_pc = 9'd0;
  endtask

  task automatic model_lit(input logic [11:0] ins);
    logic [8:0] s;
    s = {1'b0, m_w} + {1'b0, ins[7:0]};
    case (ins[9:8])
      2'b00:   m_w = ins[7:0];
      2'b01:   begin m_w = s[7:0]; m_c = s[8]; end
      2'b10:   m_w = m_w & ins[7:0];
      default: m_w = m_w | ins[7:0];
    endcase
    m_z = (m_w == 8'h00);
    m_pc = m_pc + 9'd1;
  endtask

  task automatic model_byte(input logic [11:0] ins);
    logic [4:0] f;
    logic [8:0] s;
    logic [7:0] r;
    f = ins[4:0];
    s = {1'b0, m_w} + {1'b0, m_rf[f]};
    case (ins[9:6])
      4'd2:    begin r = s[7:0]; m_c = s[8]; end
      4'd4:    r = m_w & m_rf[f];
      4'd10:   r = m_w | m_rf[f];
      default: r = m_rf[f];
    endcase
    m_z = (r == 8'h00);
    if (ins[5]) begin
      m_rf[f] = r;
      exp_wr_q.push_back({f, r});
    end else begin
      m_w = r;
    end
    m_pc = m_pc + 9'd1;
  endtask

  // Waits for the fetch request, inserts `waits` idle cycles, then returns one
  // cycle after handing over the instruction (DUT in DECODE).
  task automatic give(input logic [11:0] instr, input int waits);
    int n = 0;
    while (pm_req !== 1'b1 && n < 50) begin @(negedge clk2); n++; end
    if (pm_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: pm_req=%b, required 1", pm_req);
    end
    repeat (waits) @(negedge clk2);
    pm_valid = 1'b1;
    pm_data  = instr;
    @(negedge clk2);
    pm_valid = 1'b0;
    pm_data  = 12'($urandom);
  endtask

  task automatic to_fetch(output int cyc);
    cyc = 1;
    while (pm_req !== 1'b1 && cyc < 50) begin @(negedge clk2); cyc++; end
  endtask

  task automatic test_reset();
    reset = 1'b0; pm_valid = 1'b0; pm_data = 12'h000;
    repeat (3) @(negedge clk2);
    checks++;
    if ({pm_req, rf_we, pm_addr, rf_addr} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b we=%b pc=%0d rf_addr=%0d, required all 0", pm_req, rf_we, pm_addr, rf_addr);
    end
    checks++;
    if ({alu_inst, alu_bit, alu_a, alu_b, rf_wdata, w_reg, status} !== 41'd0) begin
      errors++;
      $display("FAIL reset_data: inst=%0d bit=%0d a=%02h b=%02h wdata=%02h w=%02h st=%b, required all 0",
               alu_inst, alu_bit, alu_a, alu_b, rf_wdata, w_reg, status);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk2);
    checks++;
    if (pm_req !== 1'b1 || pm_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_release: req=%b pc=%0d, required req=1 pc=0", pm_req, pm_addr);
    end
  endtask

  task automatic test_movlw();
    int cyc;
    give(12'h805, 0); model_lit(12'h805);
    to_fetch(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL movlw_cycles: got %0d, required 4", cyc); end
    checks++;
    if (w_reg !== 8'h05 || status !== 2'b00 || pm_addr !== 9'd1) begin
      errors++;
      $display("FAIL movlw: w=%02h st=%b pc=%0d, required w=05 st=00 pc=1", w_reg, status, pm_addr);
    end
  endtask

  task automatic test_addlw();
    int cyc;
    give(12'h8FF, 0); model_lit(12'h8FF); to_fetch(cyc);
    give(12'h901, 0); model_lit(12'h901); to_fetch(cyc);
    checks++;
    if (w_reg !== 8'h00 || status !== 2'b11 || pm_addr !== 9'd3) begin
      errors++;
      $display("FAIL addlw_carry: w=%02h st=%b pc=%0d, required w=00 st=11 pc=3", w_reg, status, pm_addr);
    end
  endtask

  task automatic test_bitop();
    int cyc;
    rf_mem[3] = 8'h01; m_rf[3] = 8'h81;
    exp_wr_q.push_back({5'd3, 8'h81});
    m_pc = m_pc + 9'd1;
    give(12'h5C3, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alu_inst !== 4'd13 || alu_bit !== 3'd7 || rf_addr !== 5'd3 || alu_b !== 8'h01) begin
        errors++;
        $display("FAIL bitset_decode[%0d]: inst=%0d bit=%0d addr=%0d b=%02h, required 13 7 3 01",
                 i, alu_inst, alu_bit, rf_addr, alu_b);
      end
      if (i < 2) @(negedge clk2);
    end
    to_fetch(cyc);
    checks++;
    if (status !== 2'b11 || w_reg !== 8'h00 || rf_mem[3] !== 8'h81 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL bitset_result: st=%b w=%02h rf3=%02h pending=%0d, required st=11 w=00 rf3=81 pending=0",
               status, w_reg, rf_mem[3], exp_wr_q.size());
    end
  endtask

  task automatic test_skip();
    int cyc;
    logic [11:0] prog [10];
    logic [8:0]  want [10];
    prog = '{12'hC0A, 12'hE00, 12'h805, 12'hC0A, 12'hE00, 12'hDFF, 12'hF00, 12'h800, 12'hDFF, 12'hE00};
    want = '{9'd10,   9'd12,   9'd13,   9'd10,   9'd11,   9'h1FF,  9'd0,    9'd1,    9'h1FF,  9'd1};
    for (int i = 0; i < 10; i++) begin
      if (prog[i][11:10] == 2'b10) model_lit(prog[i]);
      give(prog[i], 0);
      to_fetch(cyc);
      checks++;
      if (pm_addr !== want[i]) begin
        errors++;
        $display("FAIL skip_goto[%0d]: pm_addr=%0d, required %0d", i, pm_addr, want[i]);
      end
    end
    m_pc = 9'd1;
    checks++;
    if (status !== {m_c, m_z}) begin
      errors++;
      $display("FAIL skip_flags: st=%b, required %b", status, {m_c, m_z});
    end
  endtask

  task automatic test_wait();
    int cyc;
    logic [8:0] addr;
    addr = pm_addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk2);
      checks++;
      if (pm_req !== 1'b1 || pm_addr !== addr || alu_inst !== 4'd0) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: req=%b pc=%0d inst=%0d, required req=1 pc=%0d inst=0",
                 i, pm_req, pm_addr, alu_inst, addr);
      end
    end
    give(12'hF00, 0);
    to_fetch(cyc);
    m_pc = m_pc + 9'd1;
    checks++;
    if (cyc !== 4 || pm_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_wait_done: cyc=%0d pc=%0d, required cyc=4 pc=%0d", cyc, pm_addr, m_pc);
    end
  endtask

  task automatic test_valid_ignored();
    int cyc;
    give(12'h910, 0); model_lit(12'h910);
    pm_valid = 1'b1; pm_data = 12'h8AA;
    repeat (2) @(negedge clk2);
    pm_valid = 1'b0;
    to_fetch(cyc);
    checks++;
    if (w_reg !== m_w || status !== {m_c, m_z} || pm_addr !== m_pc) begin
      errors++;
      $display("FAIL valid_ignored: w=%02h st=%b pc=%0d, required w=%02h st=%b pc=%0d",
               w_reg, status, pm_addr, m_w, {m_c, m_z}, m_pc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [11:0] ins;
    logic [3:0]  ops [4];
    ops = '{4'd0, 4'd2, 4'd4, 4'd10};
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ins = {2'b10, 2'($urandom), 8'($urandom)};
        model_lit(ins);
      end else begin
        ins = {2'b00, ops[$urandom_range(0, 3)], 1'($urandom), 5'($urandom_range(0, 7))};
        model_byte(ins);
      end
      give(ins, 0);
      to_fetch(cyc);
      checks++;
      if (cyc !== 4 || w_reg !== m_w || status !== {m_c, m_z} || pm_addr !== m_pc) begin
        errors++;
        $display("FAIL b2b[%0d] ins=%03h: cyc=%0d w=%02h st=%b pc=%0d, required cyc=4 w=%02h st=%b pc=%0d",
                 i, ins, cyc, w_reg, status, pm_addr, m_w, {m_c, m_z}, m_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    give(12'h0A5, 0);
    @(negedge clk2);
    reset = 1'b0;
    @(negedge clk2);
    checks++;
    if ({pm_req, rf_we, pm_addr, w_reg, status, alu_inst, alu_bit, alu_b, rf_wdata} !== 44'd0) begin
      errors++;
      $display("FAIL reset_exec: req=%b we=%b pc=%0d w=%02h st=%b inst=%0d bit=%0d b=%02h wd=%02h, required all 0",
               pm_req, rf_we, pm_addr, w_reg, status, alu_inst, alu_bit, alu_b, rf_wdata);
    end
    reset = 1'b1;
    model_reset();
    give(12'h833, 0); model_lit(12'h833); to_fetch(cyc);
    give(12'h0A5, 0);
    @(negedge clk2);
    @(posedge clk2);
    #1 reset = 1'b0;
    @(negedge clk2);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: rf_we=%b, required 0", rf_we); end
    @(negedge clk2);
    checks++;
    if (w_reg !== 8'h00 || pm_addr !== 9'd0 || status !== 2'b00 || rf_mem[5] !== m_rf[5]) begin
      errors++;
      $display("FAIL reset_wb_state: w=%02h pc=%0d st=%b rf5=%02h, required w=00 pc=0 st=00 rf5=%02h",
               w_reg, pm_addr, status, rf_mem[5], m_rf[5]);
    end
    reset = 1'b1;
    model_reset();
    give(12'h807, 0); model_lit(12'h807); to_fetch(cyc);
    checks++;
    if (w_reg !== m_w || pm_addr !== m_pc || cyc !== 4) begin
      errors++;
      $display("FAIL reset_recover: w=%02h pc=%0d cyc=%0d, required w=%02h pc=%0d cyc=4", w_reg, pm_addr, cyc, m_w, m_pc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 8'(i * 37 + 11);
      m_rf[i]   = 8'(i * 37 + 11);
    end
    test_reset();
    test_movlw();
    test_addlw();
    test_bitop();
    test_skip();
    test_wait();
    test_valid_ignored();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Instruction sequencer that drives the 8-bit ALU: fetches 12-bit instructions from program memory and decodes them into ALU opcode, bit number and operands. It owns the PC, the W register and the C/Z status flags, then writes results back to W or the register file. It sits between program memory, the file register array and the ALU, and is the only producer of `alu_inst`/`alu_bit`.

## Interface
- `PC_W`, 9, program counter / program memory address width
- `RF_AW`, 5, register file address width
- `clk2`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `pm_addr`  out  PC_W  fetch address (= PC)
- `pm_req`  out  1  fetch request, held until `pm_valid`
- `pm_valid`  in  1  `pm_data` valid this cycle
- `pm_data`  in  12  instruction word
- `rf_addr`  out  RF_AW  file register address (= ir[4:0])
- `rf_rdata`  in  8  combinational read data at `rf_addr`
- `rf_wdata`  out  8  write data (registered ALU result)
- `rf_we`  out  1  one-cycle write strobe
- `alu_inst`  out  4  ALU opcode
- `alu_bit`  out  3  bit number for set/clear bit
- `alu_a`  out  8  ALU operand a (= W)
- `alu_b`  out  8  ALU operand b (file data or literal)
- `alu_ans`  in  8  ALU result
- `alu_carry`, `alu_z`  in  1 each  ALU flags
- `w_reg`  out  8  W register
- `status`  out  2  {C, Z}

## Operation
- Formats by ir[11:10]:
  - 00 byte op: ir[9:6] = ALU opcode, ir[5] = d (0 → W, 1 → file), ir[4:0] = f.
  - 01 bit op: ir[9] = 0 → set (ALU 13), 1 → clear (ALU 14); ir[8:6] = bit; ir[4:0] = f; always writes file.
  - 10 literal: ir[9:8] selects 00 MOVLW (ALU 0), 01 ADDLW (ALU 2), 10 ANDLW (ALU 4), 11 IORLW (ALU 10); `alu_b` = ir[7:0]; writes W.
  - 11 control: ir[9] = 0 GOTO, PC ← ir[8:0]; ir[9:8] = 10 SKIPZ, skip next if Z = 1; ir[9:8] = 11 NOP.
- `alu_b` = `rf_rdata` for formats 00/01 and ir[7:0] for format 10. `alu_inst` = 0 for format 11.
- Flags:
  - C ← `alu_carry` for ALU ops 2, 3, 8, 15.
  - Z ← `alu_z` for ALU ops 0–7, 9, 10, 12 and all literal ops.
  - Bit ops, swap and control ops leave flags unchanged.
- States: FETCH → DECODE → EXEC → WB → FETCH.
  - FETCH: `pm_req` = 1. On `pm_valid`, ir ← `pm_data`, PC ← PC+1, go to DECODE. Otherwise stay.
  - DECODE: ALU outputs and `rf_addr` driven from ir.
  - EXEC: result ← `alu_ans`. Flags captured. GOTO/SKIPZ act on PC here.
  - WB: `rf_we` = 1 if destination is file; W ← result if destination is W.
- PC arithmetic is modulo 2^PC_W: 511+1 → 0; skip from 511 → 1.
- SKIPZ uses Z as it stands at EXEC of the SKIPZ itself.

## Timing
- Reset values: PC = 0, W = 0, status = 00, ir = 12'hF00 (NOP), state FETCH, `pm_req` = 0, `rf_we` = 0, `alu_inst` = 0, `alu_bit` = 0. `rf_wdata` and `alu_b` are 0.
- `pm_req` asserts the first cycle after reset releases.
- Minimum 4 cycles per instruction when `pm_valid` returns in the request cycle. Each wait cycle adds one.
- `pm_valid` is ignored outside FETCH. `pm_data` is sampled only with `pm_valid` in FETCH.
- `alu_inst`/`alu_bit`/`alu_b`/`rf_addr` are stable from DECODE through WB.
- `rf_we` is high for exactly the WB cycle. W and status updates are visible the cycle after WB/EXEC respectively.
- Reset mid-instruction aborts it: no `rf_we`, and W/flags are reset. Reset during WB suppresses the write.

## Structure
- Package `alu_ctrl_pkg`:
  - state enum
  - format codes
  - ALU opcode localparams (PASSB = 0 … RRF = 15)
  - field slice constants
  - flag-update masks
- Sub-module `alu_ctrl_decode`: combinational, maps ir to {alu_inst, alu_bit, b_sel, dest, upd_c, upd_z, is_goto, is_skipz}.

## Test plan
- Reset, then ir = 12'b10_00_0000_0101 (MOVLW 5) with `pm_valid` immediate → W = 0x05, Z = 0, PC = 1, fetch 4 cycles apart.
- W = 0xFF, ADDLW 0x01 (12'h901) with ALU returning ans = 0x00, carry = 1, z = 1 → W = 0x00, status = 11.
- Bit set f = 3, bit 7 (12'b01_0_111_0_00011), `rf_rdata` = 0x01 → `alu_inst` = 13, `alu_bit` = 7; `rf_we` pulses once with `rf_addr` = 3 and `rf_wdata` = 0x81; flags unchanged.
- SKIPZ at PC = 10 with Z = 1 → next `pm_addr` = 12. Same with Z = 0 → 11. GOTO 0x1FF, then NOP → next `pm_addr` = 0.
- Hold `pm_valid` = 0 for 3 cycles in FETCH → `pm_req` stays high, `pm_addr` stable, no state change.
- Reset asserted during EXEC of a file-destination op → no `rf_we`, and all outputs return to their reset values the next cycle.
